// File: rtl/dff_bit_deserializer_if.sv
// Bundles the serial-bit input side and the word valid/ready output side of dff_bit_deserializer.
// The master modport belongs to the bit source and word sink. The slave modport belongs to the deserializer.
interface dff_bit_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             bit_valid;
    logic             bit_in;
    logic             clear;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overflow;
    logic             parity_err;

    modport master (
        output bit_valid, bit_in, clear, word_ready,
        input  word_data, word_valid, bit_count, overflow, parity_err
    );

    modport slave (
        input  bit_valid, bit_in, clear, word_ready,
        output word_data, word_valid, bit_count, overflow, parity_err
    );
endinterface

// File: rtl/dff_bit_deserializer.sv
// Packs the flip-flop stage's serial dout into WIDTH-bit words and delivers them through a one-word valid/ready register.
// Defining DESER_PARITY_EN adds a trailing even-parity bit to each frame and enables the sticky parity_err flag.
module dff_bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dff_bit_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] wordData_q, wordData_d;
    logic [CW-1:0]    bitCount_q, bitCount_d;
    logic             wordValid_q, wordValid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] newWord;
    logic             accept;
    logic             dataPhase;
    logic             complete;
    logic             outFree;

    assign accept   = bus.bit_valid && !bus.clear;
    assign complete = accept && (bitCount_q == LAST_BIT);
    assign outFree  = !wordValid_q || bus.word_ready;

    generate
        if (LSB_FIRST) begin : gLsbFirst
            assign shifted = {bus.bit_in, shift_q[WIDTH-1:1]};
        end else begin : gMsbFirst
            assign shifted = {shift_q[WIDTH-2:0], bus.bit_in};
        end
    endgenerate

`ifdef DESER_PARITY_EN
    // The last bit of a frame is parity only; the data word is already complete in shift_q.
    logic parityErr_q, parityErr_d;

    assign dataPhase = accept && (bitCount_q != CW'(WIDTH));
    assign newWord   = shift_q;

    always_comb begin
        parityErr_d = parityErr_q;
        if (bus.clear) begin
            parityErr_d = 1'b0;
        end else if (complete && ((^shift_q) ^ bus.bit_in)) begin
            parityErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parityErr_q <= 1'b0;
        end else begin
            parityErr_q <= parityErr_d;
        end
    end

    assign bus.parity_err = parityErr_q;
`else
    assign dataPhase      = accept;
    assign newWord        = shifted;
    assign bus.parity_err = 1'b0;
`endif

    // A completing word only lands if the output register is free; a handshake in the same cycle frees it.
    always_comb begin
        shift_d     = shift_q;
        bitCount_d  = bitCount_q;
        wordData_d  = wordData_q;
        wordValid_d = wordValid_q;
        overflow_d  = overflow_q;

        if (bus.clear) begin
            shift_d    = '0;
            bitCount_d = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            bitCount_d = complete ? '0 : bitCount_q + CW'(1);
            if (dataPhase) begin
                shift_d = shifted;
            end
        end

        if (complete) begin
            if (outFree) begin
                wordData_d  = newWord;
                wordValid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (wordValid_q && bus.word_ready) begin
            wordValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            wordData_q  <= '0;
            bitCount_q  <= '0;
            wordValid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            wordData_q  <= wordData_d;
            bitCount_q  <= bitCount_d;
            wordValid_q <= wordValid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.word_data  = wordData_q;
    assign bus.word_valid = wordValid_q;
    assign bus.bit_count  = bitCount_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_dff_bit_deserializer.sv
// Scoreboard bench for dff_bit_deserializer: an LSB-first and an MSB-first instance share one bit stream.
// Honours DESER_PARITY_EN when it is defined for the build.
module tb_dff_bit_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic bitValid = 1'b0;
    logic bitIn = 1'b0;
    logic clearIn = 1'b0;
    logic wordReady = 1'b0;

    int total = 0;
    int bad = 0;

    int       mBits[$];
    bit [W-1:0] expL[$];
    bit [W-1:0] expM[$];
    bit       mHeld = 1'b0;
    bit       mOvf = 1'b0;
    bit       mPerr = 1'b0;
    bit       rstActive = 1'b0;

    dff_bit_deserializer_if #(.WIDTH(W)) busL ();
    dff_bit_deserializer_if #(.WIDTH(W)) busM ();

    assign busL.bit_valid  = bitValid;
    assign busL.bit_in     = bitIn;
    assign busL.clear      = clearIn;
    assign busL.word_ready = wordReady;
    assign busM.bit_valid  = bitValid;
    assign busM.bit_in     = bitIn;
    assign busM.clear      = clearIn;
    assign busM.word_ready = wordReady;

    dff_bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dutL (.clk(clk), .rst_n(rst_n), .bus(busL));
    dff_bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dutM (.clk(clk), .rst_n(rst_n), .bus(busM));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBits.delete();
        expL.delete();
        expM.delete();
        mHeld = 1'b0;
        mOvf  = 1'b0;
        mPerr = 1'b0;
    endtask

    // Frame-level reference: collect bits, and when a frame is full build both word orders arithmetically.
    task automatic modelStep();
        bit complete;
        bit [W-1:0] wl;
        bit [W-1:0] wm;
        int ones;
        complete = 1'b0;
        wl = '0;
        wm = '0;
        ones = 0;
        if (rstActive) return;
        if (clearIn) begin
            mBits.delete();
            mOvf  = 1'b0;
            mPerr = 1'b0;
        end else if (bitValid) begin
            mBits.push_back(int'(bitIn));
            if (mBits.size() == FRAME) begin
                for (int i = 0; i < W; i++) begin
                    wl = wl + (W'(mBits[i]) << i);
                    wm = wm + (W'(mBits[i]) << (W - 1 - i));
                end
                for (int i = 0; i < FRAME; i++) ones += mBits[i];
`ifdef DESER_PARITY_EN
                if (ones % 2 == 1) mPerr = 1'b1;
`endif
                mBits.delete();
                complete = 1'b1;
            end
        end
        if (complete) begin
            if (!mHeld || wordReady) begin
                expL.push_back(wl);
                expM.push_back(wm);
                mHeld = 1'b1;
            end else begin
                mOvf = 1'b1;
            end
        end else if (mHeld && wordReady) begin
            mHeld = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic clr, input logic rdy);
        bitValid  = v;
        bitIn     = b;
        clearIn   = clr;
        wordReady = rdy;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // seq[0] is the first bit on the wire; with parity enabled a parity bit (optionally wrong) follows.
    task automatic sendByte(input logic [7:0] seq, input logic rdyBody, input logic rdyLast, input logic flipPar);
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0, (FRAME == W && i == W - 1) ? rdyLast : rdyBody);
        end
`ifdef DESER_PARITY_EN
        applyStimulus(1'b1, (^seq) ^ flipPar, 1'b0, rdyLast);
`else
        if (flipPar) $display("[TB] parity flip ignored without DESER_PARITY_EN");
`endif
    endtask

    task automatic applyReset();
        #2;
        rstActive = 1'b1;
        rst_n     = 1'b0;
        bitValid  = 1'b0;
        clearIn   = 1'b0;
        wordReady = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_valid", busL.word_valid, 0);
        checkOutput("rst_data", busL.word_data, 0);
        checkOutput("rst_count", busL.bit_count, 0);
        checkOutput("rst_ovf", busL.overflow, 0);
        checkOutput("rst_perr", busL.parity_err, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rstActive = 1'b0;
    endtask

    // Monitor: every cycle compare flags against the model, and pop the scoreboard on each handshake.
    always @(negedge clk) begin
        checkOutput("validL", busL.word_valid, mHeld);
        checkOutput("validM", busM.word_valid, mHeld);
        checkOutput("overflow", busL.overflow, mOvf);
        checkOutput("bitcount", busL.bit_count, mBits.size());
        checkOutput("parity", busM.parity_err, mPerr);
        if (busL.word_valid) begin
            if (expL.size() == 0 || expM.size() == 0) begin
                checkOutput("queue_empty", 1, 0);
            end else begin
                checkOutput("dataL", busL.word_data, expL[0]);
                checkOutput("dataM", busM.word_data, expM[0]);
                if (wordReady) begin
                    void'(expL.pop_front());
                    void'(expM.pop_front());
                end
            end
        end
    end

    initial begin
        applyReset();

        sendByte(8'h4D, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_lsb", busL.word_data, 32'h4D);
        checkOutput("t3_msb", busM.word_data, 32'hB2);
        checkOutput("t2_valid", busL.word_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_pulse", busL.word_valid, 0);

        sendByte(8'hA5, 1'b0, 1'b0, 1'b0);
        sendByte(8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_hold", busL.word_data, 32'hA5);
        checkOutput("t4_ovf", busL.overflow, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_drain", busL.word_valid, 0);
        checkOutput("t4_ovf_sticky", busL.overflow, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_clear", busL.overflow, 0);

        sendByte(8'h11, 1'b0, 1'b0, 1'b0);
        sendByte(8'h96, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_valid", busL.word_valid, 1);
        checkOutput("t5_data", busL.word_data, 32'h96);
        checkOutput("t5_ovf", busL.overflow, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t6_count", busL.bit_count, 0);
        sendByte(8'h4D, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_data", busL.word_data, 32'h4D);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DESER_PARITY_EN
        sendByte(8'h4D, 1'b1, 1'b1, 1'b1);
        checkOutput("par_bad", busL.parity_err, 1);
        checkOutput("par_deliver", busL.word_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        sendByte(8'h4D, 1'b1, 1'b1, 1'b0);
        checkOutput("par_good", busL.parity_err, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyReset();
        sendByte(8'h0E, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_freshL", busL.word_data, 32'h0E);
        checkOutput("t1_freshM", busM.word_data, 32'h70);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
